seg_decode_m: RTL and testbench

- Inverse of the hex-to-7-segment driver.
- Samples a 7-bit active-low segment pattern (bit6=a ... bit0=g; 7'b0000001 shows "0"), waits for it to stop changing, and decodes it to a hex nibble.
- Hands each new stable value to the UART TX path over a valid/ready byte handshake.
- Used to read the displayed digit back for UART echo and self-check.

---
 rtl/seg_decode_m.sv | 169 ++++++++++++++++
 tb/tb_seg_decode_m.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decode_m.sv
// seg_decode_m: reads back an active-low 7-segment pattern (a..g = bit6..bit0),
// waits for it to settle, decodes it to a hex digit and offers each new
// stable value as a byte on a valid/ready handshake.
//
// Optional build macro: SEG_DECODE_ASCII_EN
//   defined   -> data is ASCII ('0'-'9', 'A'-'F', '?' for an unknown glyph)
//   undefined -> data is {3'b000, err, nibble}
module seg_decode_m #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       ready,
    input  logic       clr,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       overrun,
    output logic [7:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       PAT_ZERO  = 7'b0000001;

    logic [6:0]       seg_s1_q, seg_s1_d;
    logic [6:0]       seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       last_pat_q, last_pat_d;
    logic             first_pending_q, first_pending_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             stable;
    logic             is_new;
    logic             emit;
    logic             dec_err;
    logic [3:0]       dec_nib;
    logic [7:0]       dec_byte;

    // Inverse of the driver glyph table; result is {err, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0000100: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b1100000: decode = 5'h0B;
            7'b0110001: decode = 5'h0C;
            7'b1000010: decode = 5'h0D;
            7'b0110000: decode = 5'h0E;
            7'b0111000: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    assign {dec_err, dec_nib} = decode(seg_q);

`ifdef SEG_DECODE_ASCII_EN
    // ASCII formatting of the decoded glyph, uppercase hex letters.
    always_comb begin
        if (dec_err)
            dec_byte = 8'h3F;
        else if (dec_nib < 4'd10)
            dec_byte = 8'h30 + {4'b0000, dec_nib};
        else
            dec_byte = 8'h37 + {4'b0000, dec_nib};
    end
`else
    // Raw formatting: error flag sits just above the nibble.
    always_comb begin
        dec_byte = {3'b000, dec_err, dec_nib};
    end
`endif

    // A pattern is stable once seg_q has matched seg_s1 for STABLE_CYCLES cycles.
    assign stable = (cnt_q == CNT_MAX) && (seg_s1_q == seg_q);
    assign is_new = first_pending_q || (seg_q != last_pat_q);
    assign emit   = stable && is_new && (!valid_q || ready);

    // Next-state logic: synchroniser, stability counter, handshake and status.
    always_comb begin
        seg_s1_d        = seg;
        seg_d           = seg_s1_q;
        cnt_d           = cnt_q;
        last_pat_d      = last_pat_q;
        first_pending_d = first_pending_q;
        data_d          = data_q;
        valid_d         = valid_q;
        err_d           = err_q;
        overrun_d       = overrun_q;
        err_cnt_d       = err_cnt_q;

        if (seg_s1_q != seg_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);

        if (valid_q && ready)
            valid_d = 1'b0;

        // A load on the transfer edge overrides the drop of valid.
        if (emit) begin
            data_d          = dec_byte;
            err_d           = dec_err;
            last_pat_d      = seg_q;
            first_pending_d = 1'b0;
            valid_d         = 1'b1;
        end

        // New stable value arrived while the previous byte is still stalled.
        if (stable && is_new && valid_q && !ready)
            overrun_d = 1'b1;

        if (emit && dec_err && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;

        // clr has priority over a coincident error emission.
        if (clr) begin
            overrun_d = 1'b0;
            err_cnt_d = 8'd0;
        end
    end

    // State registers with synchronous reset; reset drops any held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1_q        <= PAT_ZERO;
            seg_q           <= PAT_ZERO;
            cnt_q           <= '0;
            last_pat_q      <= PAT_ZERO;
            first_pending_q <= 1'b1;
            data_q          <= 8'd0;
            valid_q         <= 1'b0;
            err_q           <= 1'b0;
            overrun_q       <= 1'b0;
            err_cnt_q       <= 8'd0;
        end else begin
            seg_s1_q        <= seg_s1_d;
            seg_q           <= seg_d;
            cnt_q           <= cnt_d;
            last_pat_q      <= last_pat_d;
            first_pending_q <= first_pending_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            err_q           <= err_d;
            overrun_q       <= overrun_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign overrun = overrun_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_decode_m.sv
// Bench for seg_decode_m: expected bytes are queued when a pattern is driven
// and compared when the DUT transfers them.
module tb_seg_decode_m;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic       ready;
    logic       clr;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       overrun;
    logic [7:0] err_cnt;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   xfer_cnt = 0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg_decode_m #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .seg     (seg),
        .ready   (ready),
        .clr     (clr),
        .data    (data),
        .valid   (valid),
        .err     (err),
        .overrun (overrun),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input int v, input logic e);
`ifdef SEG_DECODE_ASCII_EN
        if (e) return 8'h3F;
        if (v < 10) return 8'(8'h30 + v);
        return 8'(8'h41 + v - 10);
`else
        if (e) return 8'h10;
        return 8'(v);
`endif
    endfunction

    function automatic logic is_glyph(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] rand_invalid();
        logic [6:0] p;
        p = 7'(($urandom_range(0, 127)));
        while (is_glyph(p)) p = 7'(($urandom_range(0, 127)));
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick(1);
    endtask

    // Scoreboard monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            xfer_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_xfer: got data=%h err=%b, none expected", data, err);
            end else begin
                mon_e = sb.pop_front();
                if (data !== mon_e.data || err !== mon_e.err) begin
                    n_bad++;
                    $display("FAIL xfer_data: got data=%h err=%b, expected data=%h err=%b",
                             data, err, mon_e.data, mon_e.err);
                end
            end
        end
    end

    task automatic test_reset();
        int base;
        reset = 1'b1; seg = glyph[0]; ready = 1'b1; clr = 1'b0;
        tick(3);
        n_cmp++; if (data !== 8'h00)   begin n_bad++; $display("FAIL rst_data: got %h expected 00", data); end
        n_cmp++; if (valid !== 1'b0)   begin n_bad++; $display("FAIL rst_valid: got %b expected 0", valid); end
        n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL rst_err: got %b expected 0", err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
        base = xfer_cnt;
        reset = 1'b0;
        push(exp_byte(0, 1'b0), 1'b0);
        wait_empty(20);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL first_emit: %0d bytes pending, expected 0", sb.size()); end
        tick(20);
        n_cmp++; if (xfer_cnt - base != 1) begin n_bad++; $display("FAIL first_once: got %0d transfers expected 1", xfer_cnt - base); end
    endtask

    task automatic test_latency_glitch();
        int base;
        ready = 1'b1;
        seg = glyph[5];
        push(exp_byte(5, 1'b0), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            n_cmp++;
            if (valid !== (i == 6)) begin
                n_bad++;
                $display("FAIL latency_valid: edge %0d got valid=%b expected %b", i, valid, (i == 6));
            end
        end
        wait_empty(10);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL digit5_emit: %0d pending expected 0", sb.size()); end
        base = xfer_cnt;
        seg = 7'b1111111;
        tick(3);
        seg = glyph[5];
        tick(15);
        n_cmp++; if (xfer_cnt != base) begin n_bad++; $display("FAIL glitch: got %0d transfers expected 0", xfer_cnt - base); end
    endtask

    task automatic test_stall();
        ready = 1'b0;
        seg = glyph[1];
        push(exp_byte(1, 1'b0), 1'b0);
        tick(10);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b expected 1", valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL stall_no_overrun: got %b expected 0", overrun); end
        seg = glyph[2];
        tick(10);
        n_cmp++; if (data !== exp_byte(1, 1'b0)) begin n_bad++; $display("FAIL stall_hold: got %h expected %h", data, exp_byte(1, 1'b0)); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL stall_overrun: got %b expected 1", overrun); end
        push(exp_byte(2, 1'b0), 1'b0);
        ready = 1'b1;
        wait_empty(20);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stall_drain: %0d pending expected 0", sb.size()); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_errors();
        logic [6:0] p;
        ready = 1'b1;
        seg = 7'b1111110;
        push(exp_byte(0, 1'b1), 1'b1);
        wait_empty(20);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL err_emit: %0d pending expected 0", sb.size()); end
        n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL err_cnt_1: got %0d expected 1", err_cnt); end
        for (int j = 0; j < 300; j++) begin
            p = rand_invalid();
            seg = p;
            push(exp_byte(0, 1'b1), 1'b1);
            tick(7);
            seg = glyph[j % 16];
            push(exp_byte(j % 16, 1'b0), 1'b0);
            tick(7);
            if (j == 99) begin
                n_cmp++; if (err_cnt !== 8'd101) begin n_bad++; $display("FAIL err_cnt_101: got %0d expected 101", err_cnt); end
            end
        end
        wait_empty(20);
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL err_cnt_sat: got %0d expected 255", err_cnt); end
        // clr lands on the same edge as an error emission
        seg = rand_invalid();
        push(exp_byte(0, 1'b1), 1'b1);
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL clr_coincide_emit: got valid=%b expected 1", valid); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL clr_overrun: got %b expected 0", overrun); end
        wait_empty(10);
    endtask

    task automatic test_sweep();
        ready = 1'b1;
        for (int g = 0; g < 16; g++) begin
            seg = glyph[g];
            push(exp_byte(g, 1'b0), 1'b0);
            tick(8);
        end
        wait_empty(20);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sweep_drain: %0d pending expected 0", sb.size()); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sweep_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        ready = 1'b1;
        seg = rand_invalid();
        push(exp_byte(0, 1'b1), 1'b1);
        tick(8);
        wait_empty(10);
        n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL mid_err_cnt: got %0d expected 1", err_cnt); end
        ready = 1'b0;
        seg = glyph[7];
        push(exp_byte(7, 1'b0), 1'b0);
        tick(8);
        seg = glyph[9];
        tick(8);
        n_cmp++; if (valid !== 1'b1 || data !== exp_byte(7, 1'b0)) begin
            n_bad++; $display("FAIL mid_held: got valid=%b data=%h expected 1/%h", valid, data, exp_byte(7, 1'b0));
        end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL mid_overrun: got %b expected 1", overrun); end
        dropped = sb.pop_front();
        reset = 1'b1;
        tick(1);
        n_cmp++; if (valid !== 1'b0 || data !== 8'h00 || err !== 1'b0 || overrun !== 1'b0 || err_cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset: got valid=%b data=%h err=%b overrun=%b err_cnt=%0d expected all zero (dropped %h)",
                     valid, data, err, overrun, err_cnt, dropped.data);
        end
        reset = 1'b0;
        ready = 1'b1;
        push(exp_byte(9, 1'b0), 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            n_cmp++;
            if (valid !== (i == 6)) begin
                n_bad++;
                $display("FAIL reemit_latency: edge %0d got valid=%b expected %b", i, valid, (i == 6));
            end
        end
        wait_empty(10);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL reemit: %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        reset = 1'b1;
        seg   = 7'b0000001;
        ready = 1'b0;
        clr   = 1'b0;
        test_reset();
        test_latency_glitch();
        test_stall();
        test_errors();
        test_sweep();
        test_reset_mid();
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
